quadport_ram: RTL and testbench

Responder end of the quad-port RAM interface. It receives one request per cycle from the static-priority arbiter's output side and services both single-word and four-word (`four`) read/write accesses. Storage is four interleaved banks, so any four consecutive word addresses, aligned or not, are reached in a single cycle. After reset it clears all storage, then accepts requests with registered one-cycle read data.

---
 rtl/quadport_ram_pkg.sv | 18 +
 rtl/quadport_ram_bank.sv | 25 ++
 rtl/quadport_ram.sv | 152 +++++++++++++++
 tb/tb_quadport_ram.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/quadport_ram_pkg.sv
// Shared types for the quad-port RAM responder.
// Default widths, bank count and FSM state encoding.
package quadport_ram_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int NBANKS     = 4;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [ADDR_W_DEF-3:0] row_t;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/quadport_ram_bank.sv
// One storage bank: sync write port, sync read port.
// Ports: clk, we/waddr/wdata, re/raddr, rdata (registered, holds when re=0).
module ram_bank #(
  parameter int ROW_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ROW_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ROW_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ROW_W];

  // Both ports update on the same edge, so a same-row read
  // returns the contents from before this cycle's write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/quadport_ram.sv
// Quad-port RAM responder: 4 interleaved banks, clear sweep after reset.
// Ports: CLK, nRST, addr/ren/wen/four, din_a..d, dout_a..d, init_done.
module quadport_ram
  import quadport_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ren,
  input  logic              wen,
  input  logic              four,
  input  logic [DATA_W-1:0] din_a,
  input  logic [DATA_W-1:0] din_b,
  input  logic [DATA_W-1:0] din_c,
  input  logic [DATA_W-1:0] din_d,
  output logic [DATA_W-1:0] dout_a,
  output logic [DATA_W-1:0] dout_b,
  output logic [DATA_W-1:0] dout_c,
  output logic [DATA_W-1:0] dout_d,
  output logic              init_done
);

  localparam int ROW_W = ADDR_W - 2;

  state_t            state;
  logic [ROW_W-1:0]  row_cnt;
  logic [1:0]        sel_q;
  logic              four_q;
  logic              out_en;

  logic              ready;
  logic              sweep;
  logic              acc_rd;
  logic              acc_wr;

  logic [DATA_W-1:0] lane_din [NBANKS];
  logic [DATA_W-1:0] lane_out [NBANKS];

  logic              bank_we  [NBANKS];
  logic              bank_re  [NBANKS];
  logic [ROW_W-1:0]  bank_row [NBANKS];
  logic [DATA_W-1:0] bank_wd  [NBANKS];
  logic [DATA_W-1:0] bank_rd  [NBANKS];

  logic [ADDR_W-1:0] lane_sum;
  logic [1:0]        bsel;
  logic              lane_act;
  logic [1:0]        rsel;

  assign ready     = (state == READY);
  assign sweep     = (state == INIT) && nRST;
  assign acc_rd    = ready && nRST && ren;
  assign acc_wr    = ready && nRST && wen;
  assign init_done = ready;

  assign lane_din[0] = din_a;
  assign lane_din[1] = din_b;
  assign lane_din[2] = din_c;
  assign lane_din[3] = din_d;

  // Request crossbar: lane i goes to bank (addr+i)[1:0].
  // Consecutive words always land in distinct banks.
  always_comb begin
    lane_sum = '0;
    bsel     = '0;
    lane_act = 1'b0;
    for (int b = 0; b < NBANKS; b++) begin
      bank_we[b]  = 1'b0;
      bank_re[b]  = 1'b0;
      bank_row[b] = '0;
      bank_wd[b]  = '0;
    end
    if (sweep) begin
      for (int b = 0; b < NBANKS; b++) begin
        bank_we[b]  = 1'b1;
        bank_row[b] = row_cnt;
      end
    end else begin
      for (int i = 0; i < NBANKS; i++) begin
        lane_sum = addr + ADDR_W'(i);
        bsel     = lane_sum[1:0];
        lane_act = four || (i == 0);
        bank_row[bsel] = lane_sum[ADDR_W-1:2];
        bank_wd[bsel]  = lane_din[i];
        bank_we[bsel]  = acc_wr && lane_act;
        bank_re[bsel]  = acc_rd && lane_act;
      end
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    ram_bank #(
      .ROW_W  (ROW_W),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk   (CLK),
      .we    (bank_we[b]),
      .waddr (bank_row[b]),
      .wdata (bank_wd[b]),
      .re    (bank_re[b]),
      .raddr (bank_row[b]),
      .rdata (bank_rd[b])
    );
  end

  // Return crossbar uses the address/width of the last accepted
  // read; out_en masks stale bank registers after reset.
  always_comb begin
    rsel = '0;
    for (int i = 0; i < NBANKS; i++) begin
      rsel = sel_q + 2'(i);
      if (out_en && (four_q || (i == 0)))
        lane_out[i] = bank_rd[rsel];
      else
        lane_out[i] = '0;
    end
  end

  assign dout_a = lane_out[0];
  assign dout_b = lane_out[1];
  assign dout_c = lane_out[2];
  assign dout_d = lane_out[3];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= INIT;
      row_cnt <= '0;
      sel_q   <= '0;
      four_q  <= 1'b0;
      out_en  <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          row_cnt <= row_cnt + 1'b1;
          if (row_cnt == '1) state <= READY;
        end
        READY: begin
          row_cnt <= row_cnt;
        end
      endcase
      if (acc_rd) begin
        out_en <= 1'b1;
        sel_q  <= addr[1:0];
        four_q <= four;
      end
    end
  end

endmodule

// File: tb/tb_quadport_ram.sv
// Scoreboard bench for quadport_ram.
// Driver queues expected read data; monitor checks one cycle later.
module tb_quadport_ram;
  import quadport_ram_pkg::*;

  logic        CLK;
  logic        nRST;
  logic [7:0]  addr;
  logic        ren;
  logic        wen;
  logic        four;
  logic [31:0] din_a, din_b, din_c, din_d;
  logic [31:0] dout_a, dout_b, dout_c, dout_d;
  logic        init_done;

  quadport_ram #(.ADDR_W(8), .DATA_W(32)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .addr      (addr),
    .ren       (ren),
    .wen       (wen),
    .four      (four),
    .din_a     (din_a),
    .din_b     (din_b),
    .din_c     (din_c),
    .din_d     (din_d),
    .dout_a    (dout_a),
    .dout_b    (dout_b),
    .dout_c    (dout_c),
    .dout_d    (dout_d),
    .init_done (init_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int           id;
    logic [127:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   rd_id  = 0;
  logic issued_rd = 1'b0;
  logic rd_pend   = 1'b0;

  function automatic logic [127:0] pk(input word_t a, b, c, d);
    return {a, b, c, d};
  endfunction

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic idle();
    ren = 1'b0;
    wen = 1'b0;
    four = 1'b0;
    addr = '0;
    din_a = '0;
    din_b = '0;
    din_c = '0;
    din_d = '0;
    issued_rd = 1'b0;
  endtask

  task automatic req(input logic r, w, f, input logic [7:0] a,
                     input word_t da, db, dc, dd,
                     input logic [127:0] exp);
    ren = r;
    wen = w;
    four = f;
    addr = a;
    din_a = da;
    din_b = db;
    din_c = dc;
    din_d = dd;
    if (r) begin
      sbq.push_back('{rd_id, exp});
      rd_id++;
    end
    issued_rd = r;
    @(negedge CLK);
    idle();
  endtask

  // Monitor: a read issued before a rising edge is due at the
  // following falling edge.
  always @(posedge CLK) rd_pend <= issued_rd;

  always @(negedge CLK) begin
    if (rd_pend) begin
      exp_t e;
      logic [127:0] got;
      got = {dout_a, dout_b, dout_c, dout_d};
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow got=%h exp=none", got);
      end else begin
        e = sbq.pop_front();
        if (got !== e.exp) begin
          errors++;
          $display("FAIL rd%0d got=%h exp=%h", e.id, got, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_dout", {dout_a, dout_b, dout_c, dout_d}, '0);
    chk("rst_init_done", 128'(init_done), 128'd0);
    nRST = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge CLK);
      chk($sformatf("init_done_k%0d", k), 128'(init_done),
          128'(k == 64));
    end

    req(1, 0, 1, 8'h00, 0, 0, 0, 0, pk(0, 0, 0, 0));
    req(0, 1, 1, 8'h10, 32'h11, 32'h22, 32'h33, 32'h44, '0);
    req(1, 0, 1, 8'h10, 0, 0, 0, 0,
        pk(32'h11, 32'h22, 32'h33, 32'h44));
    req(1, 0, 1, 8'h11, 0, 0, 0, 0,
        pk(32'h22, 32'h33, 32'h44, 32'h0));

    req(0, 1, 1, 8'hFE, 32'd1, 32'd2, 32'd3, 32'd4, '0);
    req(1, 0, 0, 8'hFE, 0, 0, 0, 0, pk(1, 0, 0, 0));
    req(1, 0, 0, 8'hFF, 0, 0, 0, 0, pk(2, 0, 0, 0));
    req(1, 0, 0, 8'h00, 0, 0, 0, 0, pk(3, 0, 0, 0));
    req(1, 0, 0, 8'h01, 0, 0, 0, 0, pk(4, 0, 0, 0));

    req(0, 1, 0, 8'h20, 32'h5, 32'hDEAD, 32'hBEEF, 32'hCAFE, '0);
    req(1, 0, 1, 8'h20, 0, 0, 0, 0, pk(32'h5, 0, 0, 0));
    req(1, 1, 0, 8'h20, 32'h9, 0, 0, 0, pk(32'h5, 0, 0, 0));
    req(1, 0, 0, 8'h20, 0, 0, 0, 0, pk(32'h9, 0, 0, 0));
    @(negedge CLK);
    chk("hold", {dout_a, dout_b, dout_c, dout_d}, pk(32'h9, 0, 0, 0));

    nRST = 1'b0;
    ren = 1'b1;
    four = 1'b1;
    addr = 8'h10;
    @(negedge CLK);
    chk("pulse_init_done", 128'(init_done), 128'd0);
    chk("pulse_dout", {dout_a, dout_b, dout_c, dout_d}, '0);
    idle();
    nRST = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      ren = 1'b1;
      wen = 1'b1;
      four = 1'b1;
      addr = 8'h30;
      din_a = 32'hFF;
      din_b = 32'hFF;
      din_c = 32'hFF;
      din_d = 32'hFF;
      @(negedge CLK);
      chk($sformatf("reinit_k%0d", k), 128'(init_done),
          128'(k == 64));
      if (k == 63)
        chk("reinit_dout", {dout_a, dout_b, dout_c, dout_d}, '0);
    end
    idle();
    req(1, 0, 1, 8'h10, 0, 0, 0, 0, pk(0, 0, 0, 0));
    req(1, 0, 1, 8'h30, 0, 0, 0, 0, pk(0, 0, 0, 0));
    @(negedge CLK);
    chk("sb_drained", 128'(sbq.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
